// File: rtl/bram_port_master.sv
// Single-port BRAM front end: clears the RAM on reset or on request, then serves
// valid/ready read/write requests with an in-order 3-entry read-response FIFO.
module bram_port_master #(
  parameter int unsigned ADDRLEN = 10,
  parameter int unsigned DATALEN = 32,
  parameter int unsigned DEPTH   = 1024
) (
  input  logic               clk,
  input  logic               reset_x,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDRLEN-1:0] req_addr,
  input  logic [DATALEN-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATALEN-1:0] rsp_data,
  input  logic               init_start,
  output logic               init_busy,
  output logic [ADDRLEN-1:0] ram_addr,
  output logic [DATALEN-1:0] ram_wdata,
  output logic               ram_we,
  input  logic [DATALEN-1:0] ram_rdata
);

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int unsigned FIFO_DEPTH = 3;
  localparam int unsigned CNT_W      = 2;

  logic [1:0]         state, state_nxt;
  logic [ADDRLEN-1:0] init_ptr, init_ptr_nxt;
  logic               inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   wr_ptr, rd_ptr;
  logic [DATALEN-1:0] fifo_mem [FIFO_DEPTH];
  logic               fire, push, pop, init_last;

  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == CNT_W'(FIFO_DEPTH - 1)) ? '0 : p + CNT_W'(1);
  endfunction

  // Acceptance depends only on registered state, so it never waits on rsp_ready.
  assign req_ready = (state == RUN) &&
                     ((3'(fifo_count) + 3'(inflight)) < 3'(FIFO_DEPTH));
  assign fire      = req_valid && req_ready;
  assign push      = inflight;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = fifo_mem[rd_ptr];
  assign init_busy = (state != RUN);
  assign init_last = (init_ptr == ADDRLEN'(DEPTH - 1));

  // RAM port mux: clear sweep in INIT, pass-through in RUN, no writes in DRAIN.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = req_addr;
    ram_wdata = req_wdata;
    case (state)
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = init_ptr;
        ram_wdata = '0;
      end
      RUN:     ram_we = fire && req_we;
      default: ram_we = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    case (state)
      INIT: begin
        if (init_last) begin
          state_nxt    = RUN;
          init_ptr_nxt = '0;
        end else begin
          init_ptr_nxt = init_ptr + ADDRLEN'(1);
        end
      end
      RUN: begin
        if (init_start) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!inflight && (fifo_count == '0)) state_nxt = INIT;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state      <= INIT;
      init_ptr   <= '0;
      inflight   <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      init_ptr   <= init_ptr_nxt;
      inflight   <= fire && !req_we;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Capture the RAM read data the cycle after the read was accepted.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_rdata;
  end

endmodule

// File: tb/tb_bram_port_master.sv
// Directed bench for bram_port_master with a behavioral synchronous-read RAM.
module tb_bram_port_master;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned DP = 16;

  logic          clk = 1'b0;
  logic          reset_x;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          init_start, init_busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] mem [DP];

  int n_chk  = 0;
  int n_fail = 0;

  bram_port_master #(.ADDRLEN(AW), .DATALEN(DW), .DEPTH(DP)) dut (
    .clk(clk), .reset_x(reset_x),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_start(init_start), .init_busy(init_busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expect a full clear sweep starting now; pulses init_start mid-sweep to show it is ignored.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < DP; i++) begin
      init_start = (i == 4);
      #1;
      chk({tag, "_we"},   DW'(ram_we), 32'd1);
      chk({tag, "_addr"}, DW'(ram_addr), DW'(i));
      chk({tag, "_wd"},   ram_wdata, 32'd0);
      chk({tag, "_rv"},   DW'(rsp_valid), 32'd0);
      tick();
    end
    init_start = 1'b0;
    #1;
    chk({tag, "_busy_done"},  DW'(init_busy), 32'd0);
    chk({tag, "_ready_done"}, DW'(req_ready), 32'd1);
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    #1;
    chk({tag, "_ready"}, DW'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    chk({tag, "_rv_n1"}, DW'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_rv_n2"}, DW'(rsp_valid), 32'd1);
    chk({tag, "_data"},  rsp_data, exp);
    tick();
    chk({tag, "_rv_pop"}, DW'(rsp_valid), 32'd0);
  endtask

  task automatic write_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    #1;
    chk("wr_ready", DW'(req_ready), 32'd1);
    chk("wr_ram_we", DW'(ram_we), 32'd1);
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  initial begin
    reset_x = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; init_start = 1'b0;
    #2;
    chk("rst_ready", DW'(req_ready), 32'd0);
    chk("rst_rv",    DW'(rsp_valid), 32'd0);
    chk("rst_busy",  DW'(init_busy), 32'd1);
    chk("rst_we",    DW'(ram_we), 32'd1);
    chk("rst_addr",  DW'(ram_addr), 32'd0);
    chk("rst_wd",    ram_wdata, 32'd0);
    tick(); tick();
    reset_x = 1'b1;

    // Power-up sweep, then a read of a cleared word.
    sweep_check("sweep0");
    read_check("rd5", 4'd5, 32'h0);

    // Write followed immediately by a read of the same address.
    write_req(4'd3, 32'hDEADBEEF);
    read_check("raw3", 4'd3, 32'hDEADBEEF);

    // Back-to-back reads: one response per cycle, in order.
    for (int i = 0; i < 8; i++) write_req(AW'(i), DW'(i * 32'h11));
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(c);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (c < 8) chk("b2b_ready", DW'(req_ready), 32'd1);
      if (c >= 2) begin
        chk("b2b_rv",   DW'(rsp_valid), 32'd1);
        chk("b2b_data", rsp_data, DW'((c - 2) * 32'h11));
      end else begin
        chk("b2b_rv_lead", DW'(rsp_valid), 32'd0);
      end
      tick();
    end
    chk("b2b_rv_tail", DW'(rsp_valid), 32'd0);

    // Backpressure: only three reads are accepted while rsp_ready is low.
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'((c < 3) ? c + 1 : 4);
      #1;
      chk("bp_ready", DW'(req_ready), (c < 3) ? 32'd1 : 32'd0);
      if (c < 4) tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("bp_rv0", DW'(rsp_valid), 32'd1);
    chk("bp_d0",  rsp_data, 32'h11);
    tick();
    chk("bp_d1",    rsp_data, 32'h22);
    chk("bp_ready_back", DW'(req_ready), 32'd1);
    tick();
    chk("bp_d2",  rsp_data, 32'h33);
    tick();
    chk("bp_rv_end", DW'(rsp_valid), 32'd0);

    // Re-init while two responses are buffered.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
    tick();
    req_addr = 4'd6;
    tick();
    req_valid = 1'b0;
    tick();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd0; req_wdata = 32'hFFFF_FFFF;
    #1;
    chk("drn_busy",  DW'(init_busy), 32'd1);
    chk("drn_ready", DW'(req_ready), 32'd0);
    chk("drn_we",    DW'(ram_we), 32'd0);
    chk("drn_rv",    DW'(rsp_valid), 32'd1);
    chk("drn_d0",    rsp_data, 32'h55);
    rsp_ready = 1'b1;
    tick();
    chk("drn_d1",    rsp_data, 32'h66);
    chk("drn_busy1", DW'(init_busy), 32'd1);
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    #1;
    chk("drn_rv_end", DW'(rsp_valid), 32'd0);
    chk("drn_we_end", DW'(ram_we), 32'd0);
    tick();
    sweep_check("sweep1");
    for (int c = 0; c < DP + 2; c++) begin
      if (c < DP) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(c);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (c >= 2) begin
        chk("clr_rv",   DW'(rsp_valid), 32'd1);
        chk("clr_data", rsp_data, 32'd0);
      end
      tick();
    end

    // Reset mid-operation with three responses buffered.
    write_req(4'd0, 32'hA0);
    write_req(4'd1, 32'hA1);
    write_req(4'd2, 32'hA2);
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(c);
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk("rst2_full_rv", DW'(rsp_valid), 32'd1);
    chk("rst2_full_d",  rsp_data, 32'hA0);
    reset_x = 1'b0;
    #1;
    chk("rst2_rv",    DW'(rsp_valid), 32'd0);
    chk("rst2_busy",  DW'(init_busy), 32'd1);
    chk("rst2_ready", DW'(req_ready), 32'd0);
    chk("rst2_addr",  DW'(ram_addr), 32'd0);
    tick();
    reset_x = 1'b1; rsp_ready = 1'b1;
    sweep_check("sweep2");
    chk("rst2_no_stale", DW'(rsp_valid), 32'd0);
    read_check("rst2_rd0", 4'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
